// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator and the scaled framebuffer output.
// Holds the named timing sets, the per-stage flag bundle carried down the output
// pipeline, a counter-width helper and the sync-level decode.
package vga_pkg;

   typedef struct packed {
      int unsigned h_sync;
      int unsigned h_back;
      int unsigned h_vis;
      int unsigned h_front;
      int unsigned v_sync;
      int unsigned v_back;
      int unsigned v_vis;
      int unsigned v_front;
   } vga_timing_t;

   // 64x32 upscaled into a 720-line raster, horizontally divided down.
   localparam vga_timing_t VGA_720P_LB = '{
      h_sync: 32'd4,  h_back: 32'd22, h_vis: 32'd128, h_front: 32'd11,
      v_sync: 32'd5,  v_back: 32'd60, v_vis: 32'd640, v_front: 32'd45
   };

   // Classic 640x480 @ 60 Hz.
   localparam vga_timing_t VGA_640X480 = '{
      h_sync: 32'd96, h_back: 32'd48, h_vis: 32'd640, h_front: 32'd16,
      v_sync: 32'd2,  v_back: 32'd33, v_vis: 32'd480, v_front: 32'd10
   };

   // Sync, blank and marker flags that travel together through the pipeline.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic hblank;
      logic vblank;
      logic fstart;
      logic vbstart;
   } vga_flags_t;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int unsigned width_of(input int unsigned n);
      int unsigned w;
      if (n <= 32'd1) begin
         w = 32'd1;
      end else begin
         w = $clog2(n);
      end
      return w;
   endfunction

   // Sync pin level: active polarity while the counter sits in the sync region.
   function automatic logic sync_level(input int unsigned cnt, input int unsigned sync_w,
                                       input logic pol);
      logic lvl;
      if (cnt < sync_w) begin
         lvl = pol;
      end else begin
         lvl = ~pol;
      end
      return lvl;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Stage-0 raster timing: horizontal/vertical counters plus region and sync decode.
// Ports: clk_i/rst_i (async active-high); h_cnt_o/v_cnt_o current position;
// h_vis_o/v_vis_o visible-region flags; h_last_o/v_last_o last pixel / last line;
// hsync_o/vsync_o sync levels for the current position.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_SYNC     = 32'd4,
   parameter int unsigned H_BACK     = 32'd22,
   parameter int unsigned H_VIS      = 32'd128,
   parameter int unsigned H_FRONT    = 32'd11,
   parameter int unsigned V_SYNC     = 32'd5,
   parameter int unsigned V_BACK     = 32'd60,
   parameter int unsigned V_VIS      = 32'd640,
   parameter int unsigned V_FRONT    = 32'd45,
   parameter logic        H_SYNC_POL = 1'b0,
   parameter logic        V_SYNC_POL = 1'b0,
   parameter int unsigned HW         = width_of(H_SYNC + H_BACK + H_VIS + H_FRONT + 32'd1),
   parameter int unsigned VW         = width_of(V_SYNC + V_BACK + V_VIS + V_FRONT + 32'd1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic [HW-1:0] h_cnt_o,
   output logic [VW-1:0] v_cnt_o,
   output logic          h_vis_o,
   output logic          v_vis_o,
   output logic          h_last_o,
   output logic          v_last_o,
   output logic          hsync_o,
   output logic          vsync_o
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VIS + H_FRONT;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VIS + V_FRONT;

   // Widths carry one spare count so the visible-region end never overflows.
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 32'd1);
   localparam logic [HW-1:0] H_VIS_LO = HW'(H_SYNC + H_BACK);
   localparam logic [HW-1:0] H_VIS_HI = HW'(H_SYNC + H_BACK + H_VIS);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 32'd1);
   localparam logic [VW-1:0] V_VIS_LO = VW'(V_SYNC + V_BACK);
   localparam logic [VW-1:0] V_VIS_HI = VW'(V_SYNC + V_BACK + V_VIS);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;

   assign h_cnt_o  = h_cnt_q;
   assign v_cnt_o  = v_cnt_q;
   assign h_last_o = (h_cnt_q == H_LAST);
   assign v_last_o = (v_cnt_q == V_LAST);
   assign h_vis_o  = (h_cnt_q >= H_VIS_LO) && (h_cnt_q < H_VIS_HI);
   assign v_vis_o  = (v_cnt_q >= V_VIS_LO) && (v_cnt_q < V_VIS_HI);
   assign hsync_o  = sync_level(32'(h_cnt_q), H_SYNC, H_SYNC_POL);
   assign vsync_o  = sync_level(32'(v_cnt_q), V_SYNC, V_SYNC_POL);

   // Next raster position: h wraps every line, v steps on each h wrap.
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (h_last_o) begin
         h_cnt_d = '0;
         if (v_last_o) begin
            v_cnt_d = '0;
         end else begin
            v_cnt_d = v_cnt_q + VW'(1);
         end
      end else begin
         h_cnt_d = h_cnt_q + HW'(1);
      end
   end

   // Raster position registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

endmodule

// File: rtl/vga_scaled_out.sv
// Parametrised VGA output that integer-upscales a DISP_W x DISP_H framebuffer.
// Ports: pixel_clk_i/rst_i (async active-high); fb_addr_o/fb_rd_en_o read port,
// fb_data_i returned one clock later; color_o, hsync_o, vsync_o, in_hblank_o,
// in_vblank_o video outputs, all two clocks behind the raster counters;
// frame_start_o pulse at output (0,0); vblank_start_o pulse on first front-porch line.
module vga_scaled_out
   import vga_pkg::*;
#(
   parameter int unsigned H_SYNC     = 32'd4,
   parameter int unsigned H_BACK     = 32'd22,
   parameter int unsigned H_VIS      = 32'd128,
   parameter int unsigned H_FRONT    = 32'd11,
   parameter int unsigned V_SYNC     = 32'd5,
   parameter int unsigned V_BACK     = 32'd60,
   parameter int unsigned V_VIS      = 32'd640,
   parameter int unsigned V_FRONT    = 32'd45,
   parameter int unsigned DISP_W     = 32'd64,
   parameter int unsigned DISP_H     = 32'd32,
   parameter int unsigned SCALE_X    = 32'd2,
   parameter int unsigned SCALE_Y    = 32'd20,
   parameter int unsigned COLOR_W    = 32'd1,
   parameter logic        H_SYNC_POL = 1'b0,
   parameter logic        V_SYNC_POL = 1'b0
) (
   input  logic                             pixel_clk_i,
   input  logic                             rst_i,
   output logic [$clog2(DISP_W*DISP_H)-1:0] fb_addr_o,
   output logic                             fb_rd_en_o,
   input  logic [COLOR_W-1:0]               fb_data_i,
   output logic [COLOR_W-1:0]               color_o,
   output logic                             hsync_o,
   output logic                             vsync_o,
   output logic                             in_hblank_o,
   output logic                             in_vblank_o,
   output logic                             frame_start_o,
   output logic                             vblank_start_o
);

   localparam int unsigned HW     = width_of(H_SYNC + H_BACK + H_VIS + H_FRONT + 32'd1);
   localparam int unsigned VW     = width_of(V_SYNC + V_BACK + V_VIS + V_FRONT + 32'd1);
   localparam int unsigned COL_W  = $clog2(DISP_W);
   localparam int unsigned ROW_W  = $clog2(DISP_H);
   localparam int unsigned ADDR_W = COL_W + ROW_W;
   localparam int unsigned SX_W   = width_of(SCALE_X);
   localparam int unsigned SY_W   = width_of(SCALE_Y);

   localparam logic [SX_W-1:0] SX_LAST = SX_W'(SCALE_X - 32'd1);
   localparam logic [SY_W-1:0] SY_LAST = SY_W'(SCALE_Y - 32'd1);
   localparam logic [VW-1:0]   V_VBS   = VW'(V_SYNC + V_BACK + V_VIS);

   localparam vga_flags_t FLAGS_RST = '{
      hsync: ~H_SYNC_POL, vsync: ~V_SYNC_POL, hblank: 1'b1, vblank: 1'b1,
      fstart: 1'b0, vbstart: 1'b0
   };

   if (H_VIS != DISP_W * SCALE_X) begin : g_chk_hvis
      $fatal(1, "vga_scaled_out: H_VIS must equal DISP_W*SCALE_X");
   end
   if (V_VIS != DISP_H * SCALE_Y) begin : g_chk_vvis
      $fatal(1, "vga_scaled_out: V_VIS must equal DISP_H*SCALE_Y");
   end
   if ((DISP_W < 32'd2) || ((DISP_W & (DISP_W - 32'd1)) != 32'd0) ||
       (DISP_H < 32'd2) || ((DISP_H & (DISP_H - 32'd1)) != 32'd0)) begin : g_chk_pow2
      $fatal(1, "vga_scaled_out: DISP_W and DISP_H must be powers of 2");
   end

   logic [HW-1:0] h_cnt_s;
   logic [VW-1:0] v_cnt_s;
   logic          h_vis_s, v_vis_s, h_last_s, v_last_s, hsync_s, vsync_s, vis0_s;

   vga_timing #(
      .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_VIS(H_VIS), .H_FRONT(H_FRONT),
      .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_VIS(V_VIS), .V_FRONT(V_FRONT),
      .H_SYNC_POL(H_SYNC_POL), .V_SYNC_POL(V_SYNC_POL), .HW(HW), .VW(VW)
   ) u_timing (
      .clk_i    (pixel_clk_i),
      .rst_i    (rst_i),
      .h_cnt_o  (h_cnt_s),
      .v_cnt_o  (v_cnt_s),
      .h_vis_o  (h_vis_s),
      .v_vis_o  (v_vis_s),
      .h_last_o (h_last_s),
      .v_last_o (v_last_s),
      .hsync_o  (hsync_s),
      .vsync_o  (vsync_s)
   );

   logic [SX_W-1:0]   sx_q, sx_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [SY_W-1:0]   sy_q, sy_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [ADDR_W-1:0] addr_hold_q;
   vga_flags_t        flags0_s, flags1_q, flags2_q;
   logic              vis1_q;
   logic [COLOR_W-1:0] color_d, color_q;

   assign vis0_s = h_vis_s && v_vis_s;

   // Scaler: source coordinates step by counting repeats, so no divide is needed.
   // col/row wrap naturally to 0 because H_VIS/V_VIS are exact multiples.
   always_comb begin
      sx_d  = sx_q;
      col_d = col_q;
      sy_d  = sy_q;
      row_d = row_q;
      if (vis0_s) begin
         if (sx_q == SX_LAST) begin
            sx_d  = '0;
            col_d = col_q + COL_W'(1);
         end else begin
            sx_d  = sx_q + SX_W'(1);
         end
      end else begin
         sx_d  = '0;
         col_d = '0;
      end
      if (h_last_s) begin
         if (v_last_s || !v_vis_s) begin
            sy_d  = '0;
            row_d = '0;
         end else if (sy_q == SY_LAST) begin
            sy_d  = '0;
            row_d = row_q + ROW_W'(1);
         end else begin
            sy_d  = sy_q + SY_W'(1);
         end
      end else begin
         sy_d  = sy_q;
         row_d = row_q;
      end
   end

   // Scaler coordinate registers.
   always_ff @(posedge pixel_clk_i or posedge rst_i) begin
      if (rst_i) begin
         sx_q  <= '0;
         col_q <= '0;
         sy_q  <= '0;
         row_q <= '0;
      end else begin
         sx_q  <= sx_d;
         col_q <= col_d;
         sy_q  <= sy_d;
         row_q <= row_d;
      end
   end

   // The read port is aligned with stage 0 so that RAM data meets the stage-1 flags;
   // outside the visible area the address holds the last one issued.
   assign fb_rd_en_o = vis0_s;
   assign fb_addr_o  = vis0_s ? {row_q, col_q} : addr_hold_q;

   // Address hold register for blank periods.
   always_ff @(posedge pixel_clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_hold_q <= '0;
      end else begin
         addr_hold_q <= fb_addr_o;
      end
   end

   // Stage-0 flag bundle decoded from the raster position.
   always_comb begin
      flags0_s         = FLAGS_RST;
      flags0_s.hsync   = hsync_s;
      flags0_s.vsync   = vsync_s;
      flags0_s.hblank  = ~h_vis_s;
      flags0_s.vblank  = ~v_vis_s;
      flags0_s.fstart  = (h_cnt_s == '0) && (v_cnt_s == '0);
      flags0_s.vbstart = (h_cnt_s == '0) && (v_cnt_s == V_VBS);
   end

   // Blank forcing: RAM data is only trusted when the stage-1 position is visible.
   always_comb begin
      color_d = '0;
      if (vis1_q) begin
         color_d = fb_data_i;
      end else begin
         color_d = '0;
      end
   end

   // Stage 1 (flags wait for RAM) and stage 2 (registered outputs).
   always_ff @(posedge pixel_clk_i or posedge rst_i) begin
      if (rst_i) begin
         flags1_q <= FLAGS_RST;
         vis1_q   <= 1'b0;
         flags2_q <= FLAGS_RST;
         color_q  <= '0;
      end else begin
         flags1_q <= flags0_s;
         vis1_q   <= vis0_s;
         flags2_q <= flags1_q;
         color_q  <= color_d;
      end
   end

   assign color_o        = color_q;
   assign hsync_o        = flags2_q.hsync;
   assign vsync_o        = flags2_q.vsync;
   assign in_hblank_o    = flags2_q.hblank;
   assign in_vblank_o    = flags2_q.vblank;
   assign frame_start_o  = flags2_q.fstart;
   assign vblank_start_o = flags2_q.vbstart;

endmodule

// File: tb/tb_vga_scaled_out.sv
// Bench for vga_scaled_out on a small raster (H 2/3/8/2, V 1/2/6/1, 4x2 source,
// 2x3 scaling). Two instances differ only in sync polarity. A position model
// (raster index -> h, v -> expected outputs) is compared every cycle, and
// hand-computed literals pin key points of that model.
module tb_vga_scaled_out;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic mode = 1'b0;   // 0: RAM returns addr[0] on reads, 1 otherwise; 1: always 1

   logic [2:0] addr0, addr1;
   logic rd0, rd1, col0, col1, hs0, hs1, vs0, vs1, hb0, hb1, vb0, vb1;
   logic fs0, fs1, vbs0, vbs1;
   logic fbd0 = 1'b0;
   logic fbd1 = 1'b0;

   int total = 0;
   int bad   = 0;
   int n     = 0;       // rising edges since reset release
   int last_addr[2];

   int tbl_a[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
   int tbl_c[8] = '{0, 0, 1, 1, 0, 0, 1, 1};

   always #5 clk = ~clk;

   vga_scaled_out #(
      .H_SYNC(2), .H_BACK(3), .H_VIS(8), .H_FRONT(2),
      .V_SYNC(1), .V_BACK(2), .V_VIS(6), .V_FRONT(1),
      .DISP_W(4), .DISP_H(2), .SCALE_X(2), .SCALE_Y(3), .COLOR_W(1),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
   ) dut0 (
      .pixel_clk_i(clk), .rst_i(rst), .fb_addr_o(addr0), .fb_rd_en_o(rd0),
      .fb_data_i(fbd0), .color_o(col0), .hsync_o(hs0), .vsync_o(vs0),
      .in_hblank_o(hb0), .in_vblank_o(vb0), .frame_start_o(fs0), .vblank_start_o(vbs0)
   );

   vga_scaled_out #(
      .H_SYNC(2), .H_BACK(3), .H_VIS(8), .H_FRONT(2),
      .V_SYNC(1), .V_BACK(2), .V_VIS(6), .V_FRONT(1),
      .DISP_W(4), .DISP_H(2), .SCALE_X(2), .SCALE_Y(3), .COLOR_W(1),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
   ) dut1 (
      .pixel_clk_i(clk), .rst_i(rst), .fb_addr_o(addr1), .fb_rd_en_o(rd1),
      .fb_data_i(fbd1), .color_o(col1), .hsync_o(hs1), .vsync_o(vs1),
      .in_hblank_o(hb1), .in_vblank_o(vb1), .frame_start_o(fs1), .vblank_start_o(vbs1)
   );

   // One-cycle RAM models; non-read cycles return 1 so blank forcing is exercised.
   always @(posedge clk) fbd0 <= (mode || !rd0) ? 1'b1 : addr0[0];
   always @(posedge clk) fbd1 <= (mode || !rd1) ? 1'b1 : addr1[0];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at n=%0d: got %0d, expected %0d", name, n, act, exp);
      end
   endtask

   function automatic int src_addr(input int h, input int v);
      return ((v - 3) / 3) * 4 + (h - 5) / 2;
   endfunction

   function automatic bit vis_h(input int h);
      return (h >= 5) && (h < 13);
   endfunction

   function automatic bit vis_v(input int v);
      return (v >= 3) && (v < 9);
   endfunction

   // Position model: stage 0 is raster index n, outputs show index n-2.
   task automatic model_check(input bit pol, input logic [2:0] a, input logic rd,
                              input logic c, input logic hs, input logic vs,
                              input logic hb, input logic vb, input logic fs,
                              input logic vbs);
      int e_addr, e_rd, e_c, e_hs, e_vs, e_hb, e_vb, e_fs, e_vbs, h, v;
      string p;
      p = pol ? "p1" : "p0";
      e_rd = 0; e_addr = 0; e_c = 0; e_hs = !pol; e_vs = !pol;
      e_hb = 1; e_vb = 1; e_fs = 0; e_vbs = 0;
      if (rst) begin
         last_addr[pol] = 0;
      end else begin
         h = n % 15;
         v = (n / 15) % 10;
         e_rd   = (vis_h(h) && vis_v(v)) ? 1 : 0;
         e_addr = e_rd ? src_addr(h, v) : last_addr[pol];
         last_addr[pol] = e_addr;
         if (n >= 2) begin
            h = (n - 2) % 15;
            v = ((n - 2) / 15) % 10;
            e_hs  = (h < 2) ? pol : !pol;
            e_vs  = (v < 1) ? pol : !pol;
            e_hb  = vis_h(h) ? 0 : 1;
            e_vb  = vis_v(v) ? 0 : 1;
            e_fs  = (h == 0 && v == 0) ? 1 : 0;
            e_vbs = (h == 0 && v == 9) ? 1 : 0;
            e_c   = (e_hb == 0 && e_vb == 0) ? (mode ? 1 : (src_addr(h, v) % 2)) : 0;
         end
      end
      chk({p, "_fb_rd_en"}, rd, e_rd);
      chk({p, "_fb_addr"}, a, e_addr);
      chk({p, "_color"}, c, e_c);
      chk({p, "_hsync"}, hs, e_hs);
      chk({p, "_vsync"}, vs, e_vs);
      chk({p, "_in_hblank"}, hb, e_hb);
      chk({p, "_in_vblank"}, vb, e_vb);
      chk({p, "_frame_start"}, fs, e_fs);
      chk({p, "_vblank_start"}, vbs, e_vbs);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      if (rst) n = 0;
      else n = n + 1;
      model_check(1'b0, addr0, rd0, col0, hs0, vs0, hb0, vb0, fs0, vbs0);
      model_check(1'b1, addr1, rd1, col1, hs1, vs1, hb1, vb1, fs1, vbs1);
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (n < target) begin
         step();
         guard++;
         if (guard > 2000) begin
            chk("run_to_bound", n, target);
            break;
         end
      end
   endtask

   // Start-of-frame literals after a reset release.
   task automatic check_start();
      run_to(1);
      chk("start_fs_e1", fs0, 0);
      run_to(2);
      chk("start_fs_e2", fs0, 1);
      chk("start_hs_e2", hs0, 0);
      chk("start_hs1_e2", hs1, 1);
      chk("start_vs1_e2", vs1, 1);
      run_to(3);
      chk("start_fs_e3", fs0, 0);
      chk("start_hs_e3", hs0, 0);
      run_to(4);
      chk("start_hs_e4", hs0, 1);
      chk("start_hs1_e4", hs1, 0);
      run_to(16);
      chk("start_hs_h14", hs0, 1);
      run_to(17);
      chk("start_hs_line1", hs0, 0);
      chk("start_vs1_line1", vs1, 0);
   endtask

   initial begin
      last_addr[0] = 0;
      last_addr[1] = 0;
      repeat (3) step();
      rst = 1'b0;
      check_start();

      for (int i = 0; i < 10; i++) begin
         run_to(50 + i);
         if (i < 8) begin
            chk("line3_fb_addr", addr0, tbl_a[i]);
            chk("line3_fb_rd_en", rd0, 1);
         end
         if (i >= 2) chk("line3_color", col0, tbl_c[i - 2]);
      end
      run_to(95);
      chk("row1_first_addr", addr0, 4);
      run_to(102);
      chk("row1_last_addr", addr0, 7);
      chk("row1_last_rd_en", rd0, 1);
      run_to(103);
      chk("addr_hold", addr0, 7);
      chk("addr_hold_rd_en", rd0, 0);
      run_to(136);
      chk("vbs_before", vbs0, 0);
      run_to(137);
      chk("vbs_pulse", vbs0, 1);
      run_to(138);
      chk("vbs_after", vbs0, 0);
      run_to(152);
      chk("frame_period", fs0, 1);

      // Async reset mid-line at h=7, v=4 of the second frame.
      run_to(217);
      chk("pre_reset_rd_en", rd0, 1);
      chk("pre_reset_hblank", hb0, 0);
      #2 rst = 1'b1;
      #1;
      chk("async_color", col0, 0);
      chk("async_rd_en", rd0, 0);
      chk("async_hsync", hs0, 1);
      chk("async_hsync_p1", hs1, 0);
      chk("async_hblank", hb0, 1);
      step();
      mode = 1'b1;
      step();
      rst = 1'b0;
      check_start();

      // RAM now drives 1 everywhere: color must follow blanking only.
      run_to(51);
      chk("force_hblank_color", col0, 0);
      chk("force_hblank_flag", hb0, 1);
      run_to(57);
      chk("force_vis_color", col0, 1);
      run_to(130);
      chk("force_lastrow_color", col0, 1);
      run_to(137);
      chk("force_vblank_color", col0, 0);
      chk("force_vblank_flag", vb0, 1);
      run_to(320);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
